// File: rtl/bmc_envelope_tx_if.sv
// Byte-stream handshake into the BMC envelope transmitter.
// The master drives a byte and its last flag. The slave accepts it when data_valid & data_ready at a rising edge.
`timescale 1ns/1ps
interface bmc_envelope_tx_if;
    logic [7:0] data_in;
    logic       data_valid;
    logic       data_last;
    logic       data_ready;

    modport master (output data_in, output data_valid, output data_last, input  data_ready);
    modport slave  (input  data_in, input  data_valid, input  data_last, output data_ready);
endinterface

// File: rtl/bmc_envelope_tx.sv
// Biphase-mark transmitter: serialises bytes MSB first onto d_out, framed by the active-low envelope e_out.
// A one-byte holding register lets consecutive bytes stream with no gap on the line.
`timescale 1ns/1ps
module bmc_envelope_tx #(
    parameter int unsigned HALF_BIT_CYCLES = 8,
    parameter int unsigned LEAD_CYCLES     = 4
) (
    input  logic                     clk_96MHz,
    input  logic                     rst_n,
    bmc_envelope_tx_if.slave         bus,
    output logic                     d_out,
    output logic                     e_out,
    output logic                     busy,
    output logic                     underrun
);

    typedef enum logic [1:0] {IDLE, LEAD, DATA, TAIL} state_t;

    // The counter spans a half bit only, so 8 bits cover every legal HALF_BIT_CYCLES.
    localparam logic [7:0] HALF_LAST = 8'(HALF_BIT_CYCLES - 1);
    localparam logic [7:0] LEAD_LAST = 8'(LEAD_CYCLES - 1);

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       half_q, half_d;
    logic [2:0] bit_idx_q, bit_idx_d;
    logic [7:0] shift_q, shift_d;
    logic       last_q, last_d;
    logic [7:0] hold_q, hold_d;
    logic       hold_last_q, hold_last_d;
    logic       hold_full_q, hold_full_d;
    logic       d_q, d_d;
    logic       e_q, e_d;
    logic       busy_q, busy_d;
    logic       underrun_q, underrun_d;
    logic       accept;
    logic       load;

    assign bus.data_ready = ~hold_full_q;
    assign d_out          = d_q;
    assign e_out          = e_q;
    assign busy           = busy_q;
    assign underrun       = underrun_q;

    always_comb begin
        // NOTE: every signal gets a default first, so no path through the case leaves one unassigned and infers a latch.
        state_d     = state_q;
        cnt_d       = cnt_q;
        half_d      = half_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        last_d      = last_q;
        hold_d      = hold_q;
        hold_last_d = hold_last_q;
        hold_full_d = hold_full_q;
        d_d         = d_q;
        e_d         = e_q;
        busy_d      = busy_q;
        underrun_d  = 1'b0;
        load        = 1'b0;

        // Accept needs an empty register and load needs a full one, so the two never coincide.
        accept = bus.data_valid && !hold_full_q;
        if (accept) begin
            hold_d      = bus.data_in;
            hold_last_d = bus.data_last;
            hold_full_d = 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                e_d    = 1'b1;
                d_d    = 1'b0;
                busy_d = 1'b0;
                if (hold_full_q) begin
                    state_d = LEAD;
                    e_d     = 1'b0;
                    busy_d  = 1'b1;
                    cnt_d   = 8'd0;
                    half_d  = 1'b0;
                end
            end
            LEAD: begin
                if (cnt_q == LEAD_LAST) begin
                    state_d = DATA;
                    load    = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            DATA: begin
                if (cnt_q != HALF_LAST) begin
                    cnt_d = cnt_q + 8'd1;
                end else if (!half_q) begin
                    cnt_d  = 8'd0;
                    half_d = 1'b1;
                    if (shift_q[7]) d_d = ~d_q;
                end else begin
                    // End of a bit: the boundary toggle always happens here, whatever comes next.
                    cnt_d  = 8'd0;
                    half_d = 1'b0;
                    d_d    = ~d_q;
                    if (bit_idx_q != 3'd0) begin
                        bit_idx_d = bit_idx_q - 3'd1;
                        shift_d   = {shift_q[6:0], 1'b0};
                    end else if (last_q) begin
                        state_d = TAIL;
                    end else if (hold_full_q) begin
                        load = 1'b1;
                    end else begin
                        underrun_d = 1'b1;
                        state_d    = TAIL;
                    end
                end
            end
            TAIL: begin
                if (cnt_q != HALF_LAST) begin
                    cnt_d = cnt_q + 8'd1;
                end else if (!half_q) begin
                    cnt_d  = 8'd0;
                    half_d = 1'b1;
                end else begin
                    cnt_d   = 8'd0;
                    half_d  = 1'b0;
                    state_d = IDLE;
                    e_d     = 1'b1;
                    d_d     = 1'b0;
                    busy_d  = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        if (load) begin
            shift_d     = hold_q;
            last_d      = hold_last_q;
            hold_full_d = 1'b0;
            bit_idx_d   = 3'd7;
            cnt_d       = 8'd0;
            half_d      = 1'b0;
            d_d         = ~d_q;
        end
    end

    // NOTE: the holding and shift registers are reset too; they are single flop vectors, not a memory array.
    always_ff @(posedge clk_96MHz or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= 8'd0;
            half_q      <= 1'b0;
            bit_idx_q   <= 3'd0;
            shift_q     <= 8'd0;
            last_q      <= 1'b0;
            hold_q      <= 8'd0;
            hold_last_q <= 1'b0;
            hold_full_q <= 1'b0;
            d_q         <= 1'b0;
            e_q         <= 1'b1;
            busy_q      <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make every flop update from the same pre-edge values.
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            half_q      <= half_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            last_q      <= last_d;
            hold_q      <= hold_d;
            hold_last_q <= hold_last_d;
            hold_full_q <= hold_full_d;
            d_q         <= d_d;
            e_q         <= e_d;
            busy_q      <= busy_d;
            underrun_q  <= underrun_d;
        end
    end

endmodule

// File: tb/tb_bmc_envelope_tx.sv
// Directed bench for bmc_envelope_tx.
// A line monitor timestamps d/e transitions and decodes each frame against a queue of expected bytes.
`timescale 1ns/1ps
module tb_bmc_envelope_tx;
    localparam int H    = 8;
    localparam int LEAD = 4;

    logic clk_96MHz = 1'b0;
    logic rst_n     = 1'b0;
    logic d_out, e_out, busy, underrun;

    bmc_envelope_tx_if bus ();

    bmc_envelope_tx #(.HALF_BIT_CYCLES(H), .LEAD_CYCLES(LEAD)) dut (
        .clk_96MHz (clk_96MHz),
        .rst_n     (rst_n),
        .bus       (bus),
        .d_out     (d_out),
        .e_out     (e_out),
        .busy      (busy),
        .underrun  (underrun)
    );

    always #5 clk_96MHz = ~clk_96MHz;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [7:0] exp_q [$];
    int tr [$];
    int last_tr [$];
    int frame_start = 0, frame_len = 0, rise_cyc = 0, gap_len = 0;
    int frames_done = 0, ur_cnt = 0, ur_cyc = 0, tog_total = 0;
    bit in_frame = 1'b0;
    logic prev_d, prev_e, prev_ready;

    always @(posedge clk_96MHz) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Rebuild the bit stream from transition spacing: 2H is a '0' bit, two H intervals make a '1' bit.
    task automatic decode_frame();
        int i = 1;
        int nb = 0;
        bit ok = 1'b1;
        logic [7:0] acc = 8'd0;
        logic [7:0] want;
        while (ok && i < tr.size()) begin
            if (tr[i] - tr[i-1] == 2*H) begin
                acc = {acc[6:0], 1'b0};
                i += 1;
            end else if (tr[i] - tr[i-1] == H && i + 1 < tr.size() && tr[i+1] - tr[i] == H) begin
                acc = {acc[6:0], 1'b1};
                i += 2;
            end else begin
                ok = 1'b0;
            end
            if (ok) begin
                nb++;
                if (nb % 8 == 0) begin
                    check("decode_byte_expected", exp_q.size() > 0, 1);
                    if (exp_q.size() > 0) begin
                        want = exp_q.pop_front();
                        check("decode_byte_value", acc, want);
                    end
                end
            end
        end
        check("decode_spacing_legal", ok, 1);
        check("decode_whole_bytes", nb % 8, 0);
    endtask

    initial begin
        prev_d = 1'b0;
        prev_e = 1'b1;
        prev_ready = 1'b1;
        forever begin
            @(negedge clk_96MHz);
            if (!rst_n) begin
                in_frame = 1'b0;
            end else begin
                if (d_out !== prev_d) tog_total++;
                if (prev_e && !e_out) begin
                    in_frame    = 1'b1;
                    frame_start = cyc;
                    gap_len     = cyc - rise_cyc;
                    tr.delete();
                    ur_cnt = 0;
                end
                if (in_frame && !e_out && d_out !== prev_d) tr.push_back(cyc);
                if (in_frame && underrun) begin
                    ur_cnt++;
                    ur_cyc = cyc;
                end
                if (!prev_ready && bus.data_ready && !e_out)
                    check("ready_rise_on_load", d_out !== prev_d, 1);
                if (in_frame && !prev_e && e_out) begin
                    in_frame  = 1'b0;
                    rise_cyc  = cyc;
                    frame_len = cyc - frame_start;
                    last_tr   = tr;
                    decode_frame();
                    frames_done++;
                end
            end
            prev_d     = d_out;
            prev_e     = e_out;
            prev_ready = bus.data_ready;
        end
    end

    task automatic send(input logic [7:0] b, input logic l);
        int n = 0;
        @(negedge clk_96MHz);
        bus.data_in    = b;
        bus.data_valid = 1'b1;
        bus.data_last  = l;
        while (bus.data_ready !== 1'b1 && n < 3000) begin
            @(negedge clk_96MHz);
            n++;
        end
        check("accept_within_budget", n < 3000, 1);
        exp_q.push_back(b);
        @(posedge clk_96MHz);
        #1;
        check("ready_drop_after_accept", bus.data_ready, 0);
    endtask

    task automatic end_tx();
        @(negedge clk_96MHz);
        bus.data_valid = 1'b0;
        bus.data_last  = 1'b0;
    endtask

    task automatic wait_frames(input int n);
        int k = 0;
        while (frames_done < n && k < 5000) begin
            @(negedge clk_96MHz);
            k++;
        end
        check("frame_count", frames_done, n);
    endtask

    task automatic wait_transitions(input int n);
        int k = 0;
        while (!(in_frame && tr.size() >= n) && k < 5000) begin
            @(negedge clk_96MHz);
            k++;
        end
        check("transition_wait", in_frame && tr.size() >= n, 1);
    endtask

    int saved_tog;

    initial begin
        bus.data_in    = 8'd0;
        bus.data_valid = 1'b0;
        bus.data_last  = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk_96MHz);
        check("reset_d_out", d_out, 0);
        check("reset_e_out", e_out, 1);
        check("reset_busy", busy, 0);
        check("reset_underrun", underrun, 0);
        check("reset_data_ready", bus.data_ready, 1);
        rst_n = 1'b1;
        repeat (2) @(negedge clk_96MHz);

        // Single byte 0xA5 with last.
        send(8'hA5, 1'b1);
        end_tx();
        wait_frames(1);
        check("a5_frame_len", frame_len, 148);
        check("a5_first_toggle", last_tr[0] - frame_start, LEAD);
        check("a5_transitions", last_tr.size(), 13);
        check("a5_bit7_mid", last_tr[1] - last_tr[0], H);
        check("a5_tail_len", frame_len - (last_tr[last_tr.size()-1] - frame_start), 2*H);
        check("a5_d_after", d_out, 0);
        check("a5_no_underrun", ur_cnt, 0);

        // 0x00 then 0xFF with valid held high.
        send(8'h00, 1'b0);
        send(8'hFF, 1'b1);
        end_tx();
        wait_frames(2);
        check("0ff_frame_len", frame_len, 276);
        check("0ff_transitions", last_tr.size(), 25);
        check("0ff_zero_spacing", last_tr[1] - last_tr[0], 2*H);
        check("0ff_no_gap", last_tr[8] - last_tr[7], 2*H);
        check("0ff_ones_spacing", last_tr[9] - last_tr[8], H);

        // Underrun: 0x3C not last, nothing follows.
        send(8'h3C, 1'b0);
        end_tx();
        wait_frames(3);
        check("ur_pulse_cycles", ur_cnt, 1);
        check("ur_at_tail_toggle", ur_cyc, last_tr[last_tr.size()-1]);
        check("ur_tail_len", frame_len - (last_tr[last_tr.size()-1] - frame_start), 2*H);
        check("ur_frame_len", frame_len, 148);
        check("ur_transitions", last_tr.size(), 13);
        check("ur_e_after", e_out, 1);

        // Three bytes streamed with valid held high.
        send(8'h5A, 1'b0);
        send(8'hC3, 1'b0);
        send(8'h81, 1'b1);
        end_tx();
        wait_frames(4);
        check("hs_frame_len", frame_len, 404);
        check("hs_transitions", last_tr.size(), 35);
        check("hs_queue_drained", exp_q.size(), 0);
        check("hs_no_underrun", ur_cnt, 0);

        // Back-to-back: second byte accepted while the first frame is in its tail.
        send(8'h96, 1'b1);
        end_tx();
        wait_transitions(13);
        send(8'h69, 1'b1);
        end_tx();
        wait_frames(5);
        check("b2b_first_len", frame_len, 148);
        wait_frames(6);
        check("b2b_gap", gap_len, 1);
        check("b2b_second_len", frame_len, 148);

        // Reset in the middle of bit 3 of 0xFF.
        send(8'hFF, 1'b1);
        end_tx();
        wait_transitions(9);
        check("rst_mid_e_low", e_out, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_e_out", e_out, 1);
        check("rst_mid_d_out", d_out, 0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_ready", bus.data_ready, 1);
        exp_q.delete();
        repeat (2) @(negedge clk_96MHz);
        rst_n = 1'b1;
        saved_tog = tog_total;
        repeat (50) @(negedge clk_96MHz);
        check("rst_mid_quiet", tog_total, saved_tog);
        check("rst_mid_e_idle", e_out, 1);
        check("rst_mid_busy_idle", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
